icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache.
- Sits between the instruction fetch unit and the memory controller.
- Serves fetch-unit PC lookups combinationally on a hit.
- On a miss, issues a single word fetch to the memory controller, holds the request until the instruction word comes back, fills the line, and forwards the word.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines); index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; low = freeze all state
clear_in  input  1  pipeline clear (mispredict); abandons in-flight forward
ifu_req_in  input  1  fetch unit requests instruction at ifu_pc_in
ifu_pc_in  input  32  requested PC; bits [1:0] ignored
ifu_hit_out  output  1  ifu_ins_out valid this cycle for ifu_pc_in
ifu_ins_out  output  32  instruction word
mem_fetch_out  output  1  word-fetch request to memory controller (level, held)
mem_addr_out  output  32  word-aligned fetch address
mem_back_in  input  1  memory controller returns word (one-cycle pulse)
mem_ins_in  input  32  returned word, valid with mem_back_in

Behaviour:
- Reset is async on rst_n_in low, independent of rdy_in and clock:
  - all valid bits 0; state IDLE
  - mem_fetch_out 0; mem_addr_out 0; miss address register 0
  - tag/data arrays need no reset.
- rdy_in low: no register, array or state updates; ifu_hit_out forced 0; mem_fetch_out/mem_addr_out hold.
- Lookup (combinational): array_hit = ifu_req_in && valid[idx] && tag[idx]==pc tag.
- Forward hit: state FETCH && mem_back_in && ifu_req_in && {ifu_pc_in[31:2],2'b00}==miss address.
  - forward hit drives ifu_ins_out = mem_ins_in; otherwise ifu_ins_out = data[idx].
- ifu_hit_out = rdy_in && (array_hit || forward hit).
- States: IDLE, FETCH, DISCARD (2-bit encoding).
- IDLE:
  - ifu_req_in && !array_hit && !clear_in: latch miss address = {ifu_pc_in[31:2],2'b00}; mem_addr_out <= same; mem_fetch_out <= 1; -> FETCH.
  - otherwise stay.
- FETCH:
  - mem_fetch_out and mem_addr_out held stable every cycle until mem_back_in. The memory controller may defer acceptance (load/store priority, buffer full), so dropping the request early is illegal.
  - mem_back_in && !clear_in: write tag/data at miss index, valid <= 1; mem_fetch_out <= 0; -> IDLE.
  - clear_in && !mem_back_in: -> DISCARD, request stays asserted.
  - clear_in && mem_back_in same cycle: fill line, no forward (ifu_hit_out from array only), -> IDLE.
- DISCARD:
  - request held; the word is correct memory content, so mem_back_in still fills the line.
  - no forward; -> IDLE with mem_fetch_out <= 0.
  - clear_in in DISCARD: no effect.
- Miss-to-forward latency: one cycle to raise mem_fetch_out plus memory-controller latency (≥5 cycles). The next lookup of the same PC array-hits.
- Only one outstanding fetch. New misses while FETCH/DISCARD get ifu_hit_out 0 and no new request. Array hits to other lines are still served during FETCH.
- mem_back_in in IDLE is a protocol error: ignored, no array write.
- Fill and lookup of the same index in one cycle: lookup sees old contents (except via forward).
- Mid-operation reset: all valid cleared; pending fetch forgotten (memory controller is reset alongside).

Optional Feature:
ICACHE_STATS_EN
- Defined: adds outputs hit_cnt_out[31:0] and miss_cnt_out[31:0], reset to 0.
  - hit_cnt_out +1 per rdy cycle with array_hit.
  - miss_cnt_out +1 per IDLE->FETCH transition.
  - both wrap modulo 2^32; frozen when rdy_in low.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then ifu_req_in=1, pc=0x0000_1000 -> ifu_hit_out 0.
  - next cycle mem_fetch_out=1, mem_addr_out=0x0000_1000.
  - mem_back_in with 0x0051_0113 -> same-cycle ifu_hit_out=1, ifu_ins_out=0x0051_0113; mem_fetch_out 0 next cycle.
- Repeat pc=0x0000_1000 -> immediate hit 0x0051_0113, no fetch. pc=0x0000_1100 (same index, INDEX_BITS=6) -> miss, replaces line; 0x1000 then misses again.
- Memory controller delays mem_back_in 12 cycles -> mem_fetch_out/mem_addr_out constant throughout.
- clear_in during FETCH at 0x2004, then mem_back_in -> no forward, request held until back. Line filled: later 0x2004 hits.
- rdy_in low for 3 cycles during FETCH with mem_back_in pulsed -> no fill, state unchanged. rst_n_in low mid-FETCH -> mem_fetch_out 0 immediately, all lookups miss.
- With ICACHE_STATS_EN: 1 miss + 3 hits -> miss_cnt_out=1, hit_cnt_out=3.

Source files
------------

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-per-line instruction cache
//
// Purpose:
//    Serves fetch-unit PC lookups combinationally on a hit. On a miss, raises a
//    single held word-fetch request to the memory controller, fills the line
//    when the word returns and forwards that word to the fetch unit in the same
//    cycle. Only one fetch is outstanding at a time.
//
// Optional feature macro: ICACHE_STATS_EN (adds hit/miss counters)
//
// Ports:
//    clk_in        in   1   clock, rising edge
//    rst_n_in      in   1   asynchronous active-low reset
//    rdy_in        in   1   global ready; low freezes all state
//    clear_in      in   1   pipeline clear; abandons an in-flight forward
//    ifu_req_in    in   1   fetch unit lookup request
//    ifu_pc_in     in   32  lookup PC (bits [1:0] ignored)
//    ifu_hit_out   out  1   ifu_ins_out valid for ifu_pc_in this cycle
//    ifu_ins_out   out  32  instruction word
//    mem_fetch_out out  1   word-fetch request, held until mem_back_in
//    mem_addr_out  out  32  word-aligned fetch address
//    mem_back_in   in   1   returned-word strobe (one-cycle pulse)
//    mem_ins_in    in   32  returned word
//    hit_cnt_out   out  32  array hits (ICACHE_STATS_EN only)
//    miss_cnt_out  out  32  fetches issued (ICACHE_STATS_EN only)

module icache_direct #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        clear_in,
   input  logic        ifu_req_in,
   input  logic [31:0] ifu_pc_in,
   output logic        ifu_hit_out,
   output logic [31:0] ifu_ins_out,
   output logic        mem_fetch_out,
   output logic [31:0] mem_addr_out,
   input  logic        mem_back_in,
   input  logic [31:0] mem_ins_in
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt_out,
   output logic [31:0] miss_cnt_out
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              fetch_q, fetch_d;
   logic [31:0]       miss_addr_q, miss_addr_d;
   logic [LINES-1:0]  valid_q, valid_d;

   logic [TAG_W-1:0]  tag_ram  [LINES];
   logic [31:0]       data_ram [LINES];

   logic [31:0]       pc_word;
   logic [INDEX_BITS-1:0] pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic              array_hit;
   logic              fwd_hit;
   logic              fill_en;
   logic              miss_start;

   assign pc_word  = ifu_pc_in & 32'hFFFF_FFFC;
   assign pc_idx   = pc_word[INDEX_BITS+1:2];
   assign pc_tag   = pc_word[31:INDEX_BITS+2];
   assign fill_idx = miss_addr_q[INDEX_BITS+1:2];
   assign fill_tag = miss_addr_q[31:INDEX_BITS+2];

   assign array_hit = ifu_req_in && valid_q[pc_idx] && (tag_ram[pc_idx] == pc_tag);

   // The returning word can be forwarded only while the original request is
   // still wanted: a clear in the same cycle or an earlier clear (DISCARD)
   // means the fetch unit has moved on.
   assign fwd_hit = (state_q == FETCH) && mem_back_in && !clear_in &&
                    ifu_req_in && (pc_word == miss_addr_q);

   assign ifu_hit_out   = rdy_in && (array_hit || fwd_hit);
   assign ifu_ins_out   = fwd_hit ? mem_ins_in : data_ram[pc_idx];
   assign mem_fetch_out = fetch_q;
   assign mem_addr_out  = miss_addr_q;

   always_comb begin
      state_d     = state_q;
      fetch_d     = fetch_q;
      miss_addr_d = miss_addr_q;
      valid_d     = valid_q;
      fill_en     = 1'b0;
      miss_start  = 1'b0;
      if (rdy_in) begin
         case (state_q)
            IDLE: begin
               // mem_back_in here would be a protocol error and is ignored.
               if (ifu_req_in && !array_hit && !clear_in) begin
                  miss_addr_d = pc_word;
                  fetch_d     = 1'b1;
                  state_d     = FETCH;
                  miss_start  = 1'b1;
               end
            end
            FETCH: begin
               // The request stays up until the word returns; the controller
               // may defer acceptance, so it must never be withdrawn.
               if (mem_back_in) begin
                  fill_en = 1'b1;
                  fetch_d = 1'b0;
                  state_d = IDLE;
               end else if (clear_in) begin
                  state_d = DISCARD;
               end
            end
            DISCARD: begin
               // The word is still valid memory content, so keep it.
               if (mem_back_in) begin
                  fill_en = 1'b1;
                  fetch_d = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (fill_en) begin
         valid_d[fill_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         fetch_q     <= 1'b0;
         miss_addr_q <= 32'd0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_q     <= fetch_d;
         miss_addr_q <= miss_addr_d;
         valid_q     <= valid_d;
      end
   end

   // Tag/data storage needs no reset; the valid bits gate every read.
   always_ff @(posedge clk_in) begin
      if (fill_en) begin
         tag_ram[fill_idx]  <= fill_tag;
         data_ram[fill_idx] <= mem_ins_in;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q + {31'd0, rdy_in && array_hit};
      miss_cnt_d = miss_cnt_q + {31'd0, miss_start};
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_out  = hit_cnt_q;
   assign miss_cnt_out = miss_cnt_q;
`endif

endmodule
